// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

    localparam int WORD_BYTES = 4;
    localparam int MAX_WAIT   = 15;
    localparam int CNT_W      = $clog2(MAX_WAIT + 1);

endpackage

// File: rtl/dmem_array.sv
// Word storage: one byte-enabled write port and one registered read port sharing an address.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [IDX_W-1:0]      addr,
    input  logic [WORD_BYTES-1:0] be,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Contents survive reset by design, so neither mem nor rdata is reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder in front of dmem_array with a programmable response wait.
// Define DMEM_MISALIGN_CHECK_EN to fault accesses whose addr[1:0] is non-zero.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int                DEPTH_WORDS = 1024,
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int                IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0]  CNT_INIT = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
    localparam logic [ADDR_W-1:0] DEPTH_L  = ADDR_W'(DEPTH_WORDS);
    localparam bit                NO_WAIT  = (WAIT_CYCLES == 0);

    dmem_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic [3:0]        lat_be;
    logic              err_q;

    logic              accept;
    logic              enter_resp;
    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_wdata;
    logic [3:0]        cur_be;
    logic [ADDR_W-1:0] word_off;
    logic              fault;
    logic [31:0]       arr_rdata;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

    // With no wait the access happens on the accepting edge, before the latches hold the request.
    assign cur_we    = (state == IDLE) ? req_we    : lat_we;
    assign cur_addr  = (state == IDLE) ? req_addr  : lat_addr;
    assign cur_wdata = (state == IDLE) ? req_wdata : lat_wdata;
    assign cur_be    = (state == IDLE) ? req_be    : lat_be;

    assign enter_resp = ((state == WAIT) && (cnt == '0)) || (NO_WAIT && accept);

    assign word_off = (cur_addr - BASE_ADDR) >> 2;

    always_comb begin
        fault = (cur_addr < BASE_ADDR) || (word_off >= DEPTH_L);
`ifdef DMEM_MISALIGN_CHECK_EN
        if (cur_addr[1:0] != 2'b00) fault = 1'b1;
`endif
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (enter_resp && cur_we && !fault),
        .re    (enter_resp && !cur_we && !fault),
        .addr  (word_off[IDX_W-1:0]),
        .be    (cur_be),
        .wdata (cur_wdata),
        .rdata (arr_rdata)
    );

    // RESP first spends one cycle letting the synchronous read settle, then presents the response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            err_q     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (enter_resp) err_q <= fault;
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_be    <= req_be;
                        cnt       <= CNT_INIT;
                        if (NO_WAIT) state <= RESP;
                        else         state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) state <= RESP;
                    else           cnt   <= cnt - CNT_W'(1);
                end
                RESP: begin
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= err_q;
                        rsp_rdata <= (lat_we || err_q) ? 32'h0 : arr_rdata;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised scoreboard bench for data_mem_responder against a word-array reference model.
module tb_data_mem_responder;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          W     = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .ADDR_W      (32),
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mmem [DEPTH];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          inflight = 1'b0;
    bit          prev_valid = 1'b0;
    bit          force_stall = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        rsp_ready = force_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    function automatic bit m_err(input logic [31:0] a);
        if (a < BASE) return 1'b1;
        if (((a - BASE) >> 2) >= DEPTH) return 1'b1;
`ifdef DMEM_MISALIGN_CHECK_EN
        if (a[1:0] != 2'b00) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] rand_addr();
        int          r;
        logic [31:0] a;
        r = $urandom_range(0, 9);
        if (r < 8)       a = BASE + 4 * $urandom_range(0, DEPTH - 1);
        else if (r == 8) a = BASE + 4 * DEPTH + 4 * $urandom_range(0, 7);
        else             a = BASE - 4 * $urandom_range(1, 8);
        if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        exp_t e;
        int   n;
        int   idx;
        n = 0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
        while (!req_ready) begin
            @(posedge clk); #1;
            n++;
            if (n > 200) begin
                fail("accept_timeout");
                req_valid = 1'b0;
                return;
            end
        end
        e.err   = m_err(a);
        e.rdata = '0;
        idx     = int'((a - BASE) >> 2);
        if (!e.err) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mmem[idx][8*b +: 8] = d[8*b +: 8];
            end else begin
                e.rdata = mmem[idx];
            end
        end
        e.due = cyc + 1 + W + 1;
        q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        inflight  = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((inflight || q.size() != 0) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (inflight || q.size() != 0) fail("drain_timeout");
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (inflight) chk("req_ready_busy", 32'(req_ready), 32'd0);
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    fail("unexpected_rsp");
                end else begin
                    if (!prev_valid) chk("rsp_latency", 32'(cyc), 32'(q[0].due));
                    chk("rsp_rdata", rsp_rdata, q[0].rdata);
                    chk("rsp_err", 32'(rsp_err), 32'(q[0].err));
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        inflight = 1'b0;
                    end
                end
            end
            prev_valid = rsp_valid;
        end
    end

    initial begin
        int n;
        #3;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        force_stall = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < DEPTH; i++) issue(1'b1, BASE + 4 * i, $urandom, 4'hF);

        issue(1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF);
        issue(1'b0, BASE + 32'h10, 32'h0, 4'h0);

        issue(1'b1, BASE + 32'h20, 32'h11223344, 4'hF);
        issue(1'b1, BASE + 32'h20, 32'hAAAAAAAA, 4'b0101);
        issue(1'b0, BASE + 32'h20, 32'h0, 4'hF);
        issue(1'b1, BASE + 32'h24, 32'h12345678, 4'h0);
        issue(1'b0, BASE + 32'h24, 32'h0, 4'hF);

        issue(1'b0, BASE + 4 * DEPTH, 32'h0, 4'hF);
        issue(1'b1, BASE + 4 * DEPTH, 32'h55555555, 4'hF);
        issue(1'b1, BASE - 4, 32'h66666666, 4'hF);
        issue(1'b0, BASE, 32'h0, 4'hF);
        issue(1'b0, BASE + 4 * (DEPTH - 1), 32'h0, 4'hF);

        // Response held off for several cycles while a competing request sits on the port.
        wait_idle();
        force_stall = 1'b1;
        @(posedge clk); #1;
        issue(1'b0, BASE + 32'h20, 32'h0, 4'h3);
        req_valid = 1'b1; req_we = 1'b1; req_addr = BASE + 32'h20;
        req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
        repeat (W + 6) @(posedge clk);
        #1;
        req_valid = 1'b0;
        force_stall = 1'b0;
        issue(1'b0, BASE + 32'h20, 32'h0, 4'hF);

        // Reset during WAIT drops the store in flight and leaves memory intact.
        issue(1'b1, BASE + 32'h10, 32'hCAFEF00D, 4'hF);
        wait_idle();
        req_valid = 1'b1; req_we = 1'b1; req_addr = BASE + 32'h10;
        req_wdata = 32'h0BAD0BAD; req_be = 4'hF;
        n = 0;
        while (!req_ready && n < 200) begin @(posedge clk); #1; n++; end
        if (!req_ready) fail("accept_timeout_rst");
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #2;
        inflight = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_rsp_rdata", rsp_rdata, 32'd0);
        chk("midrst_rsp_err", 32'(rsp_err), 32'd0);
        prev_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        issue(1'b0, BASE + 32'h10, 32'h0, 4'hF);

        issue(1'b1, BASE + 32'h13, 32'h77777777, 4'hF);
        issue(1'b0, BASE + 32'h10, 32'h0, 4'hF);
        issue(1'b0, BASE + 32'h12, 32'h0, 4'hF);

        repeat (300) issue(1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom));
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
